// File: rtl/exec_pkg.sv
// ============================================================================
// Module      : exec_pkg
// Description : Shared opcode and state encodings plus default widths for the
//               execute/write-back stage and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MOV = 4'd7,
        OP_MUL = 4'd8,
        OP_CMP = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/exec_stage_seq_multiplier.sv
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative shift-add multiplier, one multiplier bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_running;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    // done and product describe the final iteration, so the caller can
    // capture the full result on the same edge the last step completes.
    assign done        = r_running && (r_cnt == CW'(WIDTH - 1));
    assign product     = w_prod_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
        end else if (start) begin
            r_mcand   <= {{WIDTH{1'b0}}, a};
            r_mplier  <= b;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_running <= 1'b1;
        end else if (r_running) begin
            r_prod    <= w_prod_next;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_cnt     <= r_cnt + CW'(1);
            if (done) begin
                r_running <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
// ============================================================================
// Module      : exec_stage
// Description : Execute/write-back stage: inline ALU, sequential multiply,
//               one-cycle register file write strobe and carry/zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [AW-1:0]    dest_addr,
    output logic             wb_write,
    output logic [AW-1:0]    wb_address,
    output logic [WIDTH-1:0] wb_data,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             busy
);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_ready_en;
    logic               w_accept;
    logic               w_is_single;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;
    logic [WIDTH:0]     w_alu_wide;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_carry;
    logic [AW-1:0]      r_mul_dest;
    logic [AW-1:0]      r_wb_address;
    logic [WIDTH-1:0]   r_wb_data;
    logic               r_carry;
    logic               r_zero;

    // in_ready stays low for the first cycle after reset is released.
    assign in_ready    = r_ready_en && ((r_state == ST_IDLE) || (r_state == ST_WB));
    assign w_accept    = in_valid && in_ready;
    assign w_is_single = (opcode <= OP_MOV);
    assign busy        = (r_state == ST_MUL);
    assign wb_write    = (r_state == ST_WB);
    assign wb_address  = r_wb_address;
    assign wb_data     = r_wb_data;
    assign carry_flag  = r_carry;
    assign zero_flag   = r_zero;

    // Bit WIDTH of the widened result carries each op's carry/borrow flag.
    always_comb begin
        w_alu_wide = '0;
        case (opcode)
            OP_ADD:         w_alu_wide = {1'b0, a_in} + {1'b0, b_in};
            OP_SUB, OP_CMP: w_alu_wide = {1'b0, a_in} - {1'b0, b_in};
            OP_AND:         w_alu_wide = {1'b0, a_in & b_in};
            OP_OR:          w_alu_wide = {1'b0, a_in | b_in};
            OP_XOR:         w_alu_wide = {1'b0, a_in ^ b_in};
            OP_SHL:         w_alu_wide = {a_in, 1'b0};
            OP_SHR:         w_alu_wide = {a_in[0], 1'b0, a_in[WIDTH-1:1]};
            OP_MOV:         w_alu_wide = {1'b0, b_in};
            default:        w_alu_wide = '0;
        endcase
    end

    assign w_alu_res   = w_alu_wide[WIDTH-1:0];
    assign w_alu_carry = w_alu_wide[WIDTH];

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        case (r_state)
            ST_IDLE, ST_WB: begin
                w_state_next = ST_IDLE;
                if (w_accept) begin
                    if (w_is_single) begin
                        w_state_next = ST_WB;
                    end else if (opcode == OP_MUL) begin
                        w_state_next = ST_MUL;
                        w_mul_start  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_WB;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_dest   <= '0;
            r_wb_address <= '0;
            r_wb_data    <= '0;
            r_carry      <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_accept && w_is_single) begin
            r_wb_address <= dest_addr;
            r_wb_data    <= w_alu_res;
            if (opcode != OP_MOV) begin
                r_carry <= w_alu_carry;
                r_zero  <= (w_alu_res == '0);
            end
        end else if (w_accept && (opcode == OP_CMP)) begin
            r_carry <= w_alu_carry;
            r_zero  <= (w_alu_res == '0);
        end else if (w_accept && (opcode == OP_MUL)) begin
            r_mul_dest <= dest_addr;
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            r_wb_address <= r_mul_dest;
            r_wb_data    <= w_mul_product[WIDTH-1:0];
            r_carry      <= (w_mul_product[2*WIDTH-1:WIDTH] != '0);
            r_zero       <= (w_mul_product[WIDTH-1:0] == '0);
        end
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (a_in),
        .b       (b_in),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ============================================================================
// Module      : tb_exec_stage
// Description : Self-checking bench for exec_stage; write-backs are matched
//               against a queue of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_stage;
    import exec_pkg::*;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       c;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = 4'd0;
    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic [7:0] dest_addr = 8'd0;
    logic       wb_write;
    logic [7:0] wb_address;
    logic [7:0] wb_data;
    logic       carry_flag;
    logic       zero_flag;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e;

    exec_stage #(.WIDTH(8), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .a_in       (a_in),
        .b_in       (b_in),
        .dest_addr  (dest_addr),
        .wb_write   (wb_write),
        .wb_address (wb_address),
        .wb_data    (wb_data),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_write === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", wb_address, wb_data);
            end else begin
                e = sb.pop_front();
                if ({wb_address, wb_data, carry_flag, zero_flag} !== {e.addr, e.data, e.c, e.z}) begin
                    n_fail++;
                    $display("FAIL writeback: got addr=%h data=%h c=%b z=%b, required addr=%h data=%h c=%b z=%b",
                             wb_address, wb_data, carry_flag, zero_flag, e.addr, e.data, e.c, e.z);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] dest);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_ready_timeout: in_ready=%b, required 1", in_ready);
        end
        in_valid  = 1'b1;
        opcode    = op;
        a_in      = a;
        b_in      = b;
        dest_addr = dest;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wb_write, wb_address, wb_data, carry_flag, zero_flag, busy} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: wr=%b addr=%h data=%h c=%b z=%b busy=%b, required all 0",
                     wb_write, wb_address, wb_data, carry_flag, zero_flag, busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_add();
        sb.push_back('{addr: 8'h01, data: 8'h00, c: 1'b1, z: 1'b1});
        issue(OP_ADD, 8'hAA, 8'h56, 8'h01);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL add_latency: wb_write=%b at E+1, required 1", wb_write);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{addr: 8'h02, data: 8'hFE, c: 1'b1, z: 1'b0});
        sb.push_back('{addr: 8'h03, data: 8'hF0, c: 1'b0, z: 1'b0});
        issue(OP_SUB, 8'h03, 8'h05, 8'h02);
        issue(OP_XOR, 8'hFF, 8'h0F, 8'h03);
        n_checks++;
        if (wb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: wb_write=%b, required 1", wb_write);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: wb_write=%b, required 1", wb_write);
        end
        @(negedge clk);
        n_checks++;
        if (wb_write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_single_pulse: wb_write=%b, required 0", wb_write);
        end
    endtask

    task automatic test_mul();
        sb.push_back('{addr: 8'h04, data: 8'hA8, c: 1'b1, z: 1'b0});
        issue(OP_MUL, 8'h12, 8'h34, 8'h04);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // upstream presents another op that must be ignored while busy
                opcode    = OP_ADD;
                a_in      = 8'h01;
                b_in      = 8'h01;
                dest_addr = 8'h07;
            end
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || wb_write !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy_cycle%0d: busy=%b in_ready=%b wr=%b, required 1 0 0",
                         k, busy, in_ready, wb_write);
            end
            if (k == 8) in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (wb_write !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_latency: wr=%b busy=%b at E+9, required 1 0", wb_write, busy);
        end
    endtask

    task automatic test_reset_mid_mul();
        int writes = 0;
        issue(OP_MUL, 8'h0F, 8'h03, 8'h05);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wb_write, wb_address, wb_data, carry_flag, zero_flag, busy} !== 20'd0) begin
            n_fail++;
            $display("FAIL midmul_reset_outputs: wr=%b addr=%h data=%h c=%b z=%b busy=%b, required all 0",
                     wb_write, wb_address, wb_data, carry_flag, zero_flag, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wb_write === 1'b1) writes++;
        end
        n_checks++;
        if (writes != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midmul_no_write: writes=%0d in_ready=%b, required 0 writes and in_ready 1",
                     writes, in_ready);
        end
    endtask

    task automatic test_cmp_mov();
        issue(OP_CMP, 8'h02, 8'h02, 8'h09);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_write !== 1'b0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_flags: wr=%b z=%b c=%b, required 0 1 0", wb_write, zero_flag, carry_flag);
        end
        sb.push_back('{addr: 8'h06, data: 8'h55, c: 1'b0, z: 1'b1});
        issue(OP_MOV, 8'h00, 8'h55, 8'h06);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL mov_latency: wb_write=%b, required 1", wb_write);
        end
        @(negedge clk);
        n_checks++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL mov_flags_hold: z=%b c=%b, required 1 0", zero_flag, carry_flag);
        end
    endtask

    task automatic test_nop_shr();
        issue(4'd12, 8'h5A, 8'hA5, 8'h0A);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_write !== 1'b0 || in_ready !== 1'b1 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_no_effect: wr=%b in_ready=%b z=%b c=%b, required 0 1 1 0",
                     wb_write, in_ready, zero_flag, carry_flag);
        end
        sb.push_back('{addr: 8'h08, data: 8'h00, c: 1'b1, z: 1'b1});
        issue(OP_SHR, 8'h01, 8'h00, 8'h08);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL shr_latency: wb_write=%b, required 1", wb_write);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        test_cmp_mov();
        test_nop_shr();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected writes missing, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
